// File: rtl/fifo_pkg.sv
// Shared types and sizing for the 16x8 FIFO and its pop-side stream controller.
package fifo_pkg;

    localparam int W_DATA     = 8;
    localparam int SKID_DEPTH = 2;
    localparam int W_CNT      = 16;

    typedef logic [W_DATA-1:0] data_t;

    typedef enum logic {
        NO_POP = 1'b0,
        POP    = 1'b1
    } pop_e_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pop_state_e_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Circular skid buffer with occupancy count; absorbs read data already in flight
// from the FIFO when the downstream consumer stalls.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DEPTH = SKID_DEPTH,
    parameter int W     = W_DATA
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [W-1:0]                   wr_data,
    input  logic                           rd_en,
    output logic [W-1:0]                   rd_data,
    output logic [$clog2(DEPTH+1)-1:0]     occ
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [OW-1:0] occ_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the head is gated to zero while empty instead.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = (occ_q != '0) ? mem[rd_ptr] : '0;
    assign occ     = occ_q;

    // The pop rule upstream reserves a slot for every in-flight read.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr_en && !rd_en && (occ_q == OW'(DEPTH))));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(rd_en && (occ_q == '0)));

endmodule

// File: rtl/fifo_pop_stream.sv
// FIFO pop-side controller: issues pops, captures 1-cycle-latency read data into a
// skid buffer and presents it as a valid/ready stream with enable/drain and a beat counter.
module fifo_pop_stream
    import fifo_pkg::*;
#(
    parameter int W_DATA     = fifo_pkg::W_DATA,
    parameter int SKID_DEPTH = fifo_pkg::SKID_DEPTH,
    parameter int W_CNT      = fifo_pkg::W_CNT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enb_i,
    input  logic              fifo_empty_i,
    output pop_e_t            fifo_pop_o,
    input  logic [W_DATA-1:0] fifo_rdata_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [W_DATA-1:0] m_data_o,
    output logic              idle_o,
    output logic [W_CNT-1:0]  beats_o
);

    localparam int OW = $clog2(SKID_DEPTH + 1);

    pop_state_e_t  state;
    pop_state_e_t  state_nxt;
    logic          inflight;
    logic [OW-1:0] occ;
    logic          deq;
    logic [OW:0]   committed;
    logic [W_CNT-1:0] beats_q;

    assign m_valid_o = (occ != '0);
    assign deq       = m_valid_o && m_ready_i;
    assign idle_o    = (state == IDLE);
    assign beats_o   = beats_q;

    // Slots already spoken for once this cycle's beat leaves; one extra bit avoids overflow.
    assign committed = {1'b0, occ} + (OW+1)'(inflight) - (OW+1)'(deq);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        fifo_pop_o = NO_POP;
        if ((state == RUN) && enb_i && !fifo_empty_i &&
            (committed < (OW+1)'(SKID_DEPTH)))
            fifo_pop_o = POP;
    end

    always_ff @(posedge clk) begin
        if (rst) inflight <= 1'b0;
        else     inflight <= (fifo_pop_o == POP);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enb_i) state_nxt = RUN;
            RUN:     if (!enb_i) state_nxt = DRAIN;
            DRAIN: begin
                if (enb_i)
                    state_nxt = RUN;
                else if ((occ == '0) && !inflight)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)      beats_q <= '0;
        else if (deq) beats_q <= beats_q + 1'b1;
    end

    fifo_skid_buf #(
        .DEPTH (SKID_DEPTH),
        .W     (W_DATA)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (inflight),
        .wr_data (fifo_rdata_i),
        .rd_en   (deq),
        .rd_data (m_data_o),
        .occ     (occ)
    );

endmodule

// File: tb/tb_fifo_pop_stream.sv
// Directed bench for fifo_pop_stream: a behavioural FIFO feeds the DUT, a queue-based
// model predicts every output each cycle, and literal checks pin key scenarios.
module tb_fifo_pop_stream;
    import fifo_pkg::*;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enb;
    logic        m_ready;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata = 8'h00;
    pop_e_t      fifo_pop;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        idle;
    logic [15:0] beats;

    pop_e_t      pop4;
    logic        valid4;
    logic [7:0]  data4;
    logic        idle4;
    logic [3:0]  beats4;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    logic [7:0] fifo_mem [64];
    int wp = 0;
    int rp = 0;
    int pop_cnt = 0;

    logic [7:0] mq [$];
    bit         m_infl = 1'b0;
    logic [7:0] m_infl_data = 8'h00;
    int         mode = M_IDLE;
    int         m_beats = 0;

    always #5 clk = ~clk;

    fifo_pop_stream u_dut (
        .clk (clk), .rst (rst), .enb_i (enb), .fifo_empty_i (fifo_empty),
        .fifo_pop_o (fifo_pop), .fifo_rdata_i (fifo_rdata), .m_valid_o (m_valid),
        .m_ready_i (m_ready), .m_data_o (m_data), .idle_o (idle), .beats_o (beats)
    );

    // Narrow-counter build on the same stimulus exercises counter wrap.
    fifo_pop_stream #(.W_CNT(4)) u_dut4 (
        .clk (clk), .rst (rst), .enb_i (enb), .fifo_empty_i (fifo_empty),
        .fifo_pop_o (pop4), .fifo_rdata_i (fifo_rdata), .m_valid_o (valid4),
        .m_ready_i (m_ready), .m_data_o (data4), .idle_o (idle4), .beats_o (beats4)
    );

    assign fifo_empty = (wp == rp);

    always @(posedge clk) begin
        if (fifo_pop == POP) begin
            fifo_rdata <= fifo_mem[rp % 64];
            rp         <= rp + 1;
            pop_cnt    <= pop_cnt + 1;
        end else begin
            fifo_rdata <= 8'hEE;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        fifo_mem[wp % 64] = v;
        wp++;
    endtask

    // Per-cycle model: predict outputs from held beats, then advance on the edge's inputs.
    always @(negedge clk) begin
        logic [7:0] head_e;
        bit deq_e, pop_e, nothing_held;
        head_e = (mq.size() != 0) ? mq[0] : 8'h00;
        deq_e  = (mq.size() != 0) && m_ready;
        pop_e  = (mode == M_RUN) && enb && !fifo_empty &&
                 ((mq.size() + int'(m_infl) - int'(deq_e)) < 2);
        if (chk_en) begin
            check("cyc_pop",    32'(fifo_pop == POP), 32'(pop_e));
            check("cyc_valid",  32'(m_valid), 32'(mq.size() != 0));
            check("cyc_data",   32'(m_data), 32'(head_e));
            check("cyc_idle",   32'(idle), 32'(mode == M_IDLE));
            check("cyc_beats",  32'(beats), 32'(m_beats % 65536));
            check("cyc_beats4", 32'(beats4), 32'(m_beats % 16));
        end
        if (rst) begin
            mq.delete();
            m_infl  = 1'b0;
            mode    = M_IDLE;
            m_beats = 0;
        end else begin
            nothing_held = (mq.size() == 0) && !m_infl;
            if (deq_e) begin
                void'(mq.pop_front());
                m_beats = (m_beats + 1) % 65536;
            end
            if (m_infl) mq.push_back(m_infl_data);
            m_infl = pop_e;
            if (pop_e) m_infl_data = fifo_mem[rp % 64];
            case (mode)
                M_IDLE:  if (enb) mode = M_RUN;
                M_RUN:   if (!enb) mode = M_DRAIN;
                default: begin
                    if (enb) mode = M_RUN;
                    else if (nothing_held) mode = M_IDLE;
                end
            endcase
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int pc0;
        rst = 1'b1; enb = 1'b0; m_ready = 1'b0;
        tick(2);
        check("t1_pop",   32'(fifo_pop == POP), 32'd0);
        check("t1_valid", 32'(m_valid), 32'd0);
        check("t1_data",  32'(m_data), 32'h00);
        check("t1_idle",  32'(idle), 32'd1);
        check("t1_beats", 32'(beats), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        tick(1);

        // Stream: valid appears two edges after the edge that samples enb_i.
        for (int i = 1; i <= 16; i++) push(8'(i));
        enb = 1'b1; m_ready = 1'b1;
        tick(2);
        check("t2_not_yet_valid", 32'(m_valid), 32'd0);
        tick(1);
        check("t2_first_valid", 32'(m_valid), 32'd1);
        check("t2_data_1", 32'(m_data), 32'h01);
        for (int k = 2; k <= 16; k++) begin
            tick(1);
            check("t2_stream_valid", 32'(m_valid), 32'd1);
            check("t2_stream_data",  32'(m_data), 32'(k));
        end
        tick(1);
        check("t2_end_valid", 32'(m_valid), 32'd0);
        check("t2_beats",     32'(beats), 32'd16);
        check("t7_beats4_wrap", 32'(beats4), 32'd0);

        // Backpressure: only two reads may be outstanding.
        m_ready = 1'b0;
        pc0 = pop_cnt;
        for (int i = 1; i <= 4; i++) push(8'(i));
        tick(6);
        check("t3_pops", 32'(pop_cnt - pc0), 32'd2);
        check("t3_held_valid", 32'(m_valid), 32'd1);
        check("t3_held_data",  32'(m_data), 32'h01);
        m_ready = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            tick(1);
            check("t3_order", 32'(m_data), 32'(k));
        end
        tick(1);
        check("t3_end_valid", 32'(m_valid), 32'd0);
        check("t3_beats",  32'(beats), 32'd20);
        check("t3_beats4", 32'(beats4), 32'd4);

        // FIFO runs dry mid-stream, then refills.
        push(8'hA1); push(8'hA2);
        tick(5);
        check("t4_empty_valid", 32'(m_valid), 32'd0);
        check("t4_empty_pop",   32'(fifo_pop == POP), 32'd0);
        push(8'hA3);
        for (int i = 0; i < 10 && !m_valid; i++) tick(1);
        check("t4_resume_valid", 32'(m_valid), 32'd1);
        check("t4_resume_data",  32'(m_data), 32'hA3);
        tick(2);
        check("t4_beats", 32'(beats), 32'd23);

        // Drain with two beats held.
        m_ready = 1'b0;
        pc0 = pop_cnt;
        push(8'hB1); push(8'hB2); push(8'hB3);
        tick(4);
        check("t5_pops_before", 32'(pop_cnt - pc0), 32'd2);
        enb = 1'b0;
        tick(3);
        check("t5_pops_after", 32'(pop_cnt - pc0), 32'd2);
        check("t5_data_b1", 32'(m_data), 32'hB1);
        check("t5_not_idle", 32'(idle), 32'd0);
        m_ready = 1'b1;
        tick(1);
        check("t5_data_b2", 32'(m_data), 32'hB2);
        tick(1);
        check("t5_drained_valid", 32'(m_valid), 32'd0);
        check("t5_still_drain",   32'(idle), 32'd0);
        tick(1);
        check("t5_idle", 32'(idle), 32'd1);

        // Reset with one beat held and one read in flight.
        m_ready = 1'b0;
        push(8'hC1); push(8'hC2);
        enb = 1'b1;
        tick(3);
        check("t6_held_data", 32'(m_data), 32'hB3);
        rst = 1'b1;
        tick(1);
        check("t6_valid", 32'(m_valid), 32'd0);
        check("t6_beats", 32'(beats), 32'd0);
        check("t6_idle",  32'(idle), 32'd1);
        check("t6_data",  32'(m_data), 32'h00);
        rst = 1'b0;
        tick(3);
        check("t6_restart_data", 32'(m_data), 32'hC2);
        enb = 1'b0; m_ready = 1'b1;
        tick(6);
        check("t6_final_beats", 32'(beats), 32'd1);
        check("t6_final_idle",  32'(idle), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
